// File: rtl/pattern_scan_ctrl_pkg.sv
// Shared types and defaults for the pattern-count sequencer.
// The optional busy-cycle counter is enabled with PSCAN_PERF_EN.
package pscan_pkg;

    localparam int NUM_BYTES_DEF = 32;
    localparam int PAT_ADDR_DEF  = 32;
    localparam int RES_ADDR_DEF  = 33;
    localparam int ADDR_W_DEF    = 8;
    localparam int CNT_W         = 8;

    typedef enum logic [2:0] {
        IDLE,
        LD_PAT,
        SCAN,
        WR_CTB,
        WR_CTO,
        WR_CTS,
        DONE
    } state_e;

endpackage

// File: rtl/pattern_scan_ctrl_window_match.sv
// Combinational 5-bit window matcher over {prev_nibble, byte}.
// w[7:0] is the current byte, w[11:8] the previous byte's low nibble.
module pscan_window_match (
    input  logic [11:0] w,
    input  logic [4:0]  pat,
    input  logic        first,
    output logic [2:0]  in_cnt,
    output logic        byte_hit,
    output logic [2:0]  x_cnt
);

    logic [3:0] in_hit;
    logic [3:0] x_hit;

    // in_hit covers w[4:0]..w[7:3]; x_hit covers w[8:4]..w[11:7]
    for (genvar gi = 0; gi < 4; gi++) begin : g_win
        assign in_hit[gi] = (w[gi+4:gi] == pat);
        assign x_hit[gi]  = (w[gi+8:gi+4] == pat);
    end

    always_comb begin
        in_cnt   = {2'b00, in_hit[0]} + {2'b00, in_hit[1]}
                 + {2'b00, in_hit[2]} + {2'b00, in_hit[3]};
        byte_hit = |in_hit;
        x_cnt    = 3'd0;
        if (!first) begin
            x_cnt = {2'b00, x_hit[0]} + {2'b00, x_hit[1]}
                  + {2'b00, x_hit[2]} + {2'b00, x_hit[3]};
        end
    end

endmodule

// File: rtl/pattern_scan_ctrl.sv
// Pattern-count sequencer: reads pattern, scans NUM_BYTES bytes, writes three counts.
// Define PSCAN_PERF_EN to add the busy_cycles port.
module pattern_scan_ctrl
    import pscan_pkg::*;
#(
    parameter int NUM_BYTES = NUM_BYTES_DEF,
    parameter int PAT_ADDR  = PAT_ADDR_DEF,
    parameter int RES_ADDR  = RES_ADDR_DEF,
    parameter int ADDR_W    = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rd_data,
    output logic              mem_wr_en,
    output logic [7:0]        mem_wr_data
`ifdef PSCAN_PERF_EN
    ,
    output logic [7:0]        busy_cycles
`endif
);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [3:0]         prev_q, prev_d;
    logic [4:0]         pat_q, pat_d;
    logic [CNT_W-1:0]   ctb_q, ctb_d;
    logic [CNT_W-1:0]   cto_q, cto_d;
    logic [CNT_W-1:0]   cts_q, cts_d;

    logic [2:0] in_cnt;
    logic [2:0] x_cnt;
    logic       byte_hit;

    pscan_window_match u_match (
        .w        ({prev_q, mem_rd_data}),
        .pat      (pat_q),
        .first    (idx_q == '0),
        .in_cnt   (in_cnt),
        .byte_hit (byte_hit),
        .x_cnt    (x_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            prev_q  <= '0;
            pat_q   <= '0;
            ctb_q   <= '0;
            cto_q   <= '0;
            cts_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            prev_q  <= prev_d;
            pat_q   <= pat_d;
            ctb_q   <= ctb_d;
            cto_q   <= cto_d;
            cts_q   <= cts_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        prev_d      = prev_q;
        pat_d       = pat_q;
        ctb_d       = ctb_q;
        cto_d       = cto_q;
        cts_d       = cts_q;
        done        = 1'b0;
        busy        = 1'b0;
        mem_addr    = '0;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    state_d = LD_PAT;
                    idx_d   = '0;
                    prev_d  = '0;
                    ctb_d   = '0;
                    cto_d   = '0;
                    cts_d   = '0;
                end
            end
            LD_PAT: begin
                busy     = 1'b1;
                mem_addr = ADDR_W'(PAT_ADDR);
                pat_d    = mem_rd_data[7:3];
                state_d  = SCAN;
            end
            SCAN: begin
                busy     = 1'b1;
                mem_addr = idx_q;
                ctb_d    = ctb_q + CNT_W'(in_cnt);
                cto_d    = cto_q + CNT_W'(byte_hit);
                cts_d    = cts_q + CNT_W'(in_cnt) + CNT_W'(x_cnt);
                prev_d   = mem_rd_data[3:0];
                if (idx_q == ADDR_W'(NUM_BYTES - 1)) begin
                    state_d = WR_CTB;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            WR_CTB: begin
                busy        = 1'b1;
                mem_wr_en   = 1'b1;
                mem_addr    = ADDR_W'(RES_ADDR);
                mem_wr_data = ctb_q;
                state_d     = WR_CTO;
            end
            WR_CTO: begin
                busy        = 1'b1;
                mem_wr_en   = 1'b1;
                mem_addr    = ADDR_W'(RES_ADDR + 1);
                mem_wr_data = cto_q;
                state_d     = WR_CTS;
            end
            WR_CTS: begin
                busy        = 1'b1;
                mem_wr_en   = 1'b1;
                mem_addr    = ADDR_W'(RES_ADDR + 2);
                mem_wr_data = cts_q;
                state_d     = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PSCAN_PERF_EN
    logic [7:0] busy_cycles_q;

    // Live during a run, so it holds the final total once the run ends
    always_ff @(posedge clk) begin
        if (reset) begin
            busy_cycles_q <= '0;
        end else if ((state_q == IDLE || state_q == DONE) && start) begin
            busy_cycles_q <= '0;
        end else if (busy && busy_cycles_q != 8'hFF) begin
            busy_cycles_q <= busy_cycles_q + 8'd1;
        end
    end

    assign busy_cycles = busy_cycles_q;
`endif

endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// Scoreboard bench for pattern_scan_ctrl: expected writes are queued when a run
// is launched and popped as the DUT writes memory.
module tb_pattern_scan_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       done;
    logic       busy;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic       mem_wr_en;
    logic [7:0] mem_wr_data;
`ifdef PSCAN_PERF_EN
    logic [7:0] busy_cycles;
`endif

    always #5 clk = ~clk;

    pattern_scan_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .done        (done),
        .busy        (busy),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .mem_wr_en   (mem_wr_en),
        .mem_wr_data (mem_wr_data)
`ifdef PSCAN_PERF_EN
        ,
        .busy_cycles (busy_cycles)
`endif
    );

    logic [7:0] mem [0:255];
    assign mem_rd_data = mem[mem_addr];
    always @(posedge clk) if (mem_wr_en === 1'b1) mem[mem_addr] <= mem_wr_data;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    // Write monitor: every write must match the head of the scoreboard
    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            logic [15:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL wr_unexpected: got addr=%0d data=%0d, required no write", mem_addr, mem_wr_data);
            end else begin
                e = exp_q.pop_front();
                if ({mem_addr, mem_wr_data} !== e) begin
                    errors++;
                    $display("FAIL wr_check: got addr=%0d data=%0d, required addr=%0d data=%0d",
                             mem_addr, mem_wr_data, e[15:8], e[7:0]);
                end else begin
                    $display("write addr=%0d data=%0d ok", mem_addr, mem_wr_data);
                end
            end
        end
    end

    // Golden model: all 5-bit windows of the 256-bit big-endian string
    task automatic golden(output logic [7:0] ctb, output logic [7:0] cto, output logic [7:0] cts);
        logic [255:0] s;
        logic [4:0]   p;
        logic [31:0]  hitb;
        for (int i = 0; i < 32; i++) s[255-8*i -: 8] = mem[i];
        p    = mem[32][7:3];
        ctb  = 0;
        cts  = 0;
        hitb = 0;
        for (int t = 255; t >= 4; t--) begin
            if (s[t -: 5] == p) begin
                cts++;
                if ((t / 8) == ((t - 4) / 8)) begin
                    ctb++;
                    hitb[(255 - t) / 8] = 1'b1;
                end
            end
        end
        cto = 8'($countones(hitb));
    endtask

    task automatic push_exp(input logic [7:0] ctb, input logic [7:0] cto, input logic [7:0] cts);
        exp_q.push_back({8'd33, ctb});
        exp_q.push_back({8'd34, cto});
        exp_q.push_back({8'd35, cts});
    endtask

    task automatic preload_results(input logic [7:0] v);
        mem[33] = v;
        mem[34] = v;
        mem[35] = v;
    endtask

    // Waits for done counting edges since the start-sampling edge E0
    task automatic wait_done(input string name, input int already);
        int cycles;
        cycles = already;
        while (cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (done === 1'b1) break;
        end
        checks++;
        if (done !== 1'b1 || cycles != 36) begin
            errors++;
            $display("FAIL %s latency: got done=%b after %0d cycles, required done=1 after 36", name, done, cycles);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_at_done: got %b, required 0", name, busy);
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s missing_writes: got %0d pending, required 0", name, exp_q.size());
        end
        exp_q.delete();
`ifdef PSCAN_PERF_EN
        checks++;
        if (busy_cycles !== 8'd36) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d, required 36", name, busy_cycles);
        end
`endif
        $display("run %s: done after %0d cycles, results %0d %0d %0d", name, cycles, mem[33], mem[34], mem[35]);
    endtask

    task automatic launch_and_wait(input string name);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(name, 0);
    endtask

    task automatic run_fixed(input string name, input logic [7:0] ctb, input logic [7:0] cto, input logic [7:0] cts);
        preload_results(8'hAA);
        push_exp(ctb, cto, cts);
        launch_and_wait(name);
    endtask

    task automatic fill(input logic [7:0] even_b, input logic [7:0] odd_b, input logic [4:0] pat);
        for (int i = 0; i < 32; i++) mem[i] = (i % 2 == 0) ? even_b : odd_b;
        mem[32] = {pat, 3'b101};
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({done, busy, mem_wr_en} !== 3'b000 || mem_addr !== 8'd0 || mem_wr_data !== 8'd0) begin
            errors++;
            $display("FAIL reset_outputs: got done=%b busy=%b we=%b addr=%0d data=%0d, required all 0",
                     done, busy, mem_wr_en, mem_addr, mem_wr_data);
        end
`ifdef PSCAN_PERF_EN
        checks++;
        if (busy_cycles !== 8'd0) begin
            errors++;
            $display("FAIL reset_busy_cycles: got %0d, required 0", busy_cycles);
        end
`endif
        @(negedge clk) reset = 1'b0;
        $display("reset: outputs checked");
    endtask

    task automatic test_fixed_patterns();
        fill(8'h00, 8'h00, 5'b00000); run_fixed("zeros_pat0", 8'd128, 8'd32, 8'd252);
        fill(8'h55, 8'h55, 5'b10101); run_fixed("x55_pat10101", 8'd64, 8'd32, 8'd126);
        fill(8'hFF, 8'hFF, 5'b11111); run_fixed("ones_pat1f", 8'd128, 8'd32, 8'd252);
        fill(8'h00, 8'h00, 5'b11111); run_fixed("zeros_pat1f", 8'd0, 8'd0, 8'd0);
        fill(8'h0F, 8'hF0, 5'b11111); run_fixed("crossing_only", 8'd0, 8'd0, 8'd64);
    endtask

    task automatic test_reset_midrun();
        logic [7:0] a, b, c;
        for (int i = 0; i < 33; i++) mem[i] = 8'($urandom);
        preload_results(8'hAA);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (11) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || mem_addr !== 8'd10) begin
            errors++;
            $display("FAIL midrun_position: got busy=%b addr=%0d, required busy=1 addr=10", busy, mem_addr);
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrun_reset_state: got done=%b busy=%b, required 0 0", done, busy);
        end
        checks++;
        if (mem[33] !== 8'hAA || mem[34] !== 8'hAA || mem[35] !== 8'hAA) begin
            errors++;
            $display("FAIL midrun_results_untouched: got %h %h %h, required aa aa aa", mem[33], mem[34], mem[35]);
        end
        $display("midrun reset: state and results checked");
        golden(a, b, c);
        push_exp(a, b, c);
        launch_and_wait("after_midrun_reset");
    endtask

    task automatic test_back_to_back();
        logic [7:0] a, b, c;
        fill(8'h55, 8'h55, 5'b10101);
        preload_results(8'hAA);
        push_exp(8'd64, 8'd32, 8'd126);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        repeat (4) @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("start_held", 15);
        repeat (4) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_holds: got done=%b busy=%b, required 1 0", done, busy);
        end
        fill(8'hC3, 8'h3C, 5'b01111);
        golden(a, b, c);
        preload_results(8'hAA);
        push_exp(a, b, c);
        launch_and_wait("rerun_from_done");
    endtask

    task automatic test_random();
        logic [7:0] a, b, c;
        for (int r = 0; r < 200; r++) begin
            for (int i = 0; i < 33; i++) mem[i] = 8'($urandom);
            if (r % 4 == 0) begin
                for (int i = 0; i < 32; i++) mem[i] = (i % 3 == 0) ? 8'hF8 : 8'($urandom_range(0, 255));
            end
            preload_results(8'($urandom));
            golden(a, b, c);
            push_exp(a, b, c);
            launch_and_wait($sformatf("random_%0d", r));
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        test_reset();
        test_fixed_patterns();
        test_reset_midrun();
        test_back_to_back();
        test_random();
        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
